bit_serial_logic_ctrl: RTL and testbench
========================================

# bit_serial_logic_ctrl

Sequencer that time-multiplexes one 1-bit logic slice (AND/OR/XOR/NAND gate cell) across a WIDTH-bit word, one bit per clock, LSB first. It accepts a request via a start/busy/done handshake, latches operands and opcode, and steps a bit counter through the word. It then presents the assembled result plus a zero flag. It sits between the CPU-side register file and the shared gate slice, and is the only block that drives the slice's operand and select inputs.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 2..32
- clock  input  1  rising-edge clock; all state changes on this edge
- reset_n  input  1  synchronous active-low reset, sampled on the clock edge
- start  input  1  request; sampled only in IDLE
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND
- a  input  WIDTH  operand A; sampled only on the accepting edge
- b  input  WIDTH  operand B; sampled only on the accepting edge
- busy  output  1  high while the word is being processed (state RUN)
- done  output  1  one-cycle pulse: result in out is complete
- out  output  WIDTH  result register
- zr  output  1  high when out == 0

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: if start=1, latch a, b and op into internal shift registers, clear bit counter cnt to 0, clear out to 0, go to RUN. If start=0, stay; out holds its last value.
- RUN: each edge applies the slice to the LSBs of the A/B shift registers under the latched op. The resulting bit is shifted into out from the MSB side, so after WIDTH steps bit i of the result sits at out[i]. A and B shift right by one; cnt increments. On the edge where cnt == WIDTH-1, go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally to IDLE. start is ignored in DONE.
- start in RUN or DONE is ignored; it is not queued. Changes on a, b or op after acceptance have no effect.
- cnt width is ceil(log2(WIDTH)) bits and never wraps: the RUN to DONE transition happens at WIDTH-1.
- zr is combinational from out (NOR of all out bits). It is meaningful when done=1 or in IDLE. During RUN it reflects the partially built word.
- Slice function per bit: AND a&b, OR a|b, XOR a^b, NAND ~(a&b).

## Timing
- Reset (reset_n=0 at an edge): state IDLE, busy=0, done=0, out=0, zr=1, cnt=0. Shift registers are cleared to 0.
- Reset takes priority over every other input. Reset during RUN or DONE aborts the operation: no done pulse, and out is cleared.
- Accept at edge E0 (IDLE, start=1): busy=1 from E0.
- Edges E1..E_WIDTH: each processes one bit.
- After E_WIDTH: busy=0, done=1, and out holds the full result.
- After E_WIDTH+1: done=0, state IDLE.
- Latency from the accepting edge to done visible: WIDTH edges. done stays high for 1 cycle.
- Minimum spacing between accepting edges: WIDTH+2 edges. With start held high continuously, the next accept occurs at E_WIDTH+2.
- busy and done are never high in the same cycle. busy is high for exactly WIDTH cycles per operation.

## Test plan
- Reset, then WIDTH=16, op=00, a=0x00FF, b=0x0F0F, 1-cycle start -> busy high 16 cycles; done pulses 16 edges after accept with out=0x000F, zr=0.
- op=10, a=b=0xA5A5 -> done with out=0x0000, zr=1. Then op=11, a=b=0x0000 -> out=0xFFFF, zr=0.
- op=01, a=0x8001, b=0x0000; during RUN toggle start and change a/b/op to random values -> out=0x8001, single done pulse, no second operation started.
- start held high continuously with op=00, a=b=0xFFFF -> accepts at E0 and E18; done pulses at E16 and E34 (cycles after those edges); out=0xFFFF for both.
- Start an op=00, a=b=0xFFFF operation; assert reset_n=0 at edge E8 -> after that edge busy=0, done=0, out=0, zr=1. No done pulse follows. A fresh start after release behaves normally.
- Idle hold: after a completed op=10, a=0x1234, b=0x00FF, keep start=0 for 20 cycles -> out stays 0x12CB, busy=0, done=0.

Source files
------------

// File: rtl/bit_serial_logic_ctrl.sv
// bit_serial_logic_ctrl
// Time-multiplexes a single 1-bit gate slice (AND/OR/XOR/NAND) across a
// WIDTH-bit word, LSB first, one bit per clock. A request is taken with a
// start/busy/done handshake. The assembled result and a zero flag are held
// until the next accepted request.
module bit_serial_logic_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zr
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             slice_bit;

    // The shared gate cell: one result bit from one bit of each operand.
    function automatic logic gate_slice(input logic x, input logic y,
                                        input logic [1:0] sel);
        logic r;
        case (sel)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            default: r = ~(x & y);
        endcase
        return r;
    endfunction

    // Slice is fed from the LSBs of the operand shift registers.
    always_comb begin
        slice_bit = gate_slice(sh_a[0], sh_b[0], op_q);
    end

    // Sequencer: accept, step WIDTH bits, pulse done, return to idle.
    // The counter holds at the last bit index instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            op_q  <= 2'b00;
            cnt   <= '0;
            out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        op_q  <= op;
                        cnt   <= '0;
                        out   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // New bit enters at the MSB; after WIDTH steps bit i lands at out[i].
                    out  <= {slice_bit, out[WIDTH-1:1]};
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    if (cnt == LAST_BIT) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded straight from state and the result register.
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
        zr   = ~|out;
    end

endmodule

// File: tb/tb_bit_serial_logic_ctrl.sv
// Self-checking bench for bit_serial_logic_ctrl (WIDTH=16).
// Expected results are queued when a request is issued and popped when done
// is observed.
module tb_bit_serial_logic_ctrl;

    localparam int WIDTH = 16;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             start   = 1'b0;
    logic [1:0]       op      = 2'b00;
    logic [WIDTH-1:0] a       = '0;
    logic [WIDTH-1:0] b       = '0;
    logic             busy;
    logic             done;
    logic             zr;
    logic [WIDTH-1:0] out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [WIDTH-1:0] exp_q[$];

    bit_serial_logic_ctrl #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .out     (out),
        .zr      (zr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // One-cycle start pulse; t0 is the cycle stamp of the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, output int t0);
        @(posedge clock);
        #1;
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(model(o, x, y));
        @(posedge clock);
        #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    // Watch outputs on falling edges until done (bounded). With noisy set,
    // start/op/a/b are scrambled every cycle until done is seen.
    task automatic wait_done(input int limit, input bit noisy, output bit got,
                             output int t_done, output int nbusy, output bit overlap,
                             output logic [WIDTH-1:0] o_out, output logic o_zr);
        got = 1'b0; t_done = 0; nbusy = 0; overlap = 1'b0; o_out = '0; o_zr = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (busy && done) overlap = 1'b1;
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1; t_done = cyc; o_out = out; o_zr = zr;
                if (noisy) start = 1'b0;
                break;
            end
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0 || zr !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b out=%h zr=%b, want 0 0 0000 1",
                     busy, done, out, zr);
        end
    endtask

    task automatic test_and();
        int t0, td, nb; bit got, ov; logic [WIDTH-1:0] o; logic z; logic [WIDTH-1:0] e;
        issue(2'b00, 16'h00FF, 16'h0F0F, t0);
        wait_done(40, 1'b0, got, td, nb, ov, o, z);
        tests++;
        if (!got) begin
            fails++; $display("FAIL and_done: no done pulse within 40 cycles");
        end else begin
            e = exp_q.pop_front();
            tests++;
            if (o !== e || z !== 1'b0) begin
                fails++; $display("FAIL and_result: out=%h zr=%b, want %h 0", o, z, e);
            end
            tests++;
            if (td - t0 !== WIDTH) begin
                fails++; $display("FAIL and_latency: %0d edges, want %0d", td - t0, WIDTH);
            end
            tests++;
            if (nb !== WIDTH || ov) begin
                fails++; $display("FAIL and_busy: busy cycles=%0d overlap=%b, want %0d 0", nb, ov, WIDTH);
            end
        end
    endtask

    task automatic test_xor_nand();
        int t0, td, nb; bit got, ov; logic [WIDTH-1:0] o; logic z; logic [WIDTH-1:0] e;
        issue(2'b10, 16'hA5A5, 16'hA5A5, t0);
        wait_done(40, 1'b0, got, td, nb, ov, o, z);
        tests++;
        if (!got) begin
            fails++; $display("FAIL xor_done: no done pulse within 40 cycles");
        end else begin
            e = exp_q.pop_front();
            tests++;
            if (o !== e || z !== 1'b1) begin
                fails++; $display("FAIL xor_result: out=%h zr=%b, want %h 1", o, z, e);
            end
        end
        issue(2'b11, 16'h0000, 16'h0000, t0);
        wait_done(40, 1'b0, got, td, nb, ov, o, z);
        tests++;
        if (!got) begin
            fails++; $display("FAIL nand_done: no done pulse within 40 cycles");
        end else begin
            e = exp_q.pop_front();
            tests++;
            if (o !== e || z !== 1'b0) begin
                fails++; $display("FAIL nand_result: out=%h zr=%b, want %h 0", o, z, e);
            end
        end
    endtask

    task automatic test_ignore_inputs();
        int t0, td, nb; bit got, ov; logic [WIDTH-1:0] o; logic z; logic [WIDTH-1:0] e;
        int extra_busy;
        issue(2'b01, 16'h8001, 16'h0000, t0);
        wait_done(40, 1'b1, got, td, nb, ov, o, z);
        tests++;
        if (!got) begin
            fails++; $display("FAIL ignore_done: no done pulse within 40 cycles");
        end else begin
            e = exp_q.pop_front();
            tests++;
            if (o !== e || td - t0 !== WIDTH) begin
                fails++; $display("FAIL ignore_result: out=%h after %0d edges, want %h after %0d",
                                  o, td - t0, e, WIDTH);
            end
        end
        extra_busy = 0;
        repeat (10) begin
            @(negedge clock);
            if (busy || done) extra_busy++;
        end
        tests++;
        if (extra_busy !== 0 || exp_q.size() !== 0) begin
            fails++; $display("FAIL ignore_no_second_op: busy/done cycles=%0d, want 0", extra_busy);
        end
    endtask

    task automatic test_back_to_back();
        int t0, td, nb; bit got, ov; logic [WIDTH-1:0] o; logic z; logic [WIDTH-1:0] e;
        @(posedge clock);
        #1;
        op = 2'b00; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clock);
        #1;
        t0 = cyc;
        exp_q.push_back(model(2'b00, 16'hFFFF, 16'hFFFF));
        exp_q.push_back(model(2'b00, 16'hFFFF, 16'hFFFF));
        for (int k = 0; k < 2; k++) begin
            wait_done(40, 1'b0, got, td, nb, ov, o, z);
            tests++;
            if (!got) begin
                fails++; $display("FAIL b2b_done%0d: no done pulse within 40 cycles", k);
            end else begin
                e = exp_q.pop_front();
                tests++;
                if (o !== e || td - t0 !== WIDTH + k * (WIDTH + 2)) begin
                    fails++; $display("FAIL b2b_op%0d: out=%h at edge %0d, want %h at edge %0d",
                                      k, o, td - t0, e, WIDTH + k * (WIDTH + 2));
                end
                tests++;
                if (nb !== WIDTH || ov) begin
                    fails++; $display("FAIL b2b_busy%0d: busy cycles=%0d overlap=%b, want %0d 0",
                                      k, nb, ov, WIDTH);
                end
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL b2b_stop: busy=%b after start released, want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        int t0, td, nb, late_done; bit got, ov; logic [WIDTH-1:0] o; logic z; logic [WIDTH-1:0] e;
        issue(2'b00, 16'hFFFF, 16'hFFFF, t0);
        e = exp_q.pop_back();
        repeat (7) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0 || zr !== 1'b1) begin
            fails++;
            $display("FAIL abort_state: busy=%b done=%b out=%h zr=%b, want 0 0 0000 1",
                     busy, done, out, zr);
        end
        late_done = 0;
        repeat (25) begin
            @(negedge clock);
            if (done || busy) late_done++;
        end
        tests++;
        if (late_done !== 0) begin
            fails++; $display("FAIL abort_no_done: busy/done cycles=%0d after reset, want 0", late_done);
        end
        issue(2'b01, 16'h0F00, 16'h00F0, t0);
        wait_done(40, 1'b0, got, td, nb, ov, o, z);
        tests++;
        if (!got) begin
            fails++; $display("FAIL abort_fresh_done: no done pulse within 40 cycles");
        end else begin
            e = exp_q.pop_front();
            tests++;
            if (o !== e || td - t0 !== WIDTH) begin
                fails++; $display("FAIL abort_fresh_result: out=%h after %0d edges, want %h after %0d",
                                  o, td - t0, e, WIDTH);
            end
        end
    endtask

    task automatic test_idle_hold();
        int t0, td, nb, bad; bit got, ov; logic [WIDTH-1:0] o; logic z; logic [WIDTH-1:0] e;
        issue(2'b10, 16'h1234, 16'h00FF, t0);
        wait_done(40, 1'b0, got, td, nb, ov, o, z);
        e = 16'h12CB;
        tests++;
        if (!got) begin
            fails++; $display("FAIL hold_done: no done pulse within 40 cycles");
        end else begin
            e = exp_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++; $display("FAIL hold_result: out=%h, want %h", o, e);
            end
        end
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            tests++;
            if (out !== e || busy !== 1'b0 || zr !== 1'b0) begin
                fails++; bad++;
                if (bad < 4)
                    $display("FAIL hold_idle: out=%h busy=%b zr=%b, want %h 0 0", out, busy, zr, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_xor_nand();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_abort();
        test_idle_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
